// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: add_i encodings, FSM states,
// the buffered command record and a saturating counter helper.
package apb_seq_pkg;

  localparam int SEQ_DATA_W = 32;

  typedef enum logic [1:0] {
    ADD_IDLE  = 2'b00,
    ADD_READ  = 2'b01,
    ADD_WRITE = 2'b11
  } add_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    RESP
  } seq_state_e;

  typedef struct packed {
    logic                  write;
    logic [SEQ_DATA_W-1:0] wdata;
  } seq_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_seq_fifo.sv
// Synchronous command FIFO for the sequencer; first-word-fall-through head,
// push ignored when full and pop ignored when empty.
module apb_seq_fifo
  import apb_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  seq_cmd_t                 i_push_data,
  input  logic                     i_pop,
  output seq_cmd_t                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  seq_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Host command front-end for apb_master_slave_top: one APB transfer in flight,
// timeout abort, response handshake. APB_SEQ_STATS_EN adds completion counters.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int DATA_W         = SEQ_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_write_i,
  input  logic [DATA_W-1:0]             cmd_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_write_o,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic [1:0]                    add_o,
  output logic [DATA_W-1:0]             external_wdata_o,
`ifdef APB_SEQ_STATS_EN
  output logic [15:0]                   wr_done_o,
  output logic [15:0]                   rd_done_o,
  output logic [15:0]                   err_cnt_o,
`endif
  input  logic                          apb_ready_i,
  input  logic [DATA_W-1:0]             apb_rdata_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e          r_state;
  add_cmd_e            r_add;
  logic                r_cur_write;
  logic [TW-1:0]       r_timer;
  logic [DATA_W-1:0]   r_ext_wdata;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_valid;
  logic                r_rsp_write;
  logic                r_rsp_err;

  seq_cmd_t            w_push_cmd;
  seq_cmd_t            w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  assign w_push = cmd_valid_i && !w_full;
  // A ready still high in IDLE belongs to the previous transfer; wait for it to drop.
  assign w_pop  = (r_state == IDLE) && !w_empty && !apb_ready_i;

  always_comb begin
    w_push_cmd       = '0;
    w_push_cmd.write = cmd_write_i;
    w_push_cmd.wdata = SEQ_DATA_W'(cmd_wdata_i);
  end

  apb_seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (pclk),
    .rst         (preset),
    .i_push      (w_push),
    .i_push_data (w_push_cmd),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count_o)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      r_add       <= ADD_IDLE;
      r_cur_write <= 1'b0;
      r_timer     <= '0;
      r_ext_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cur_write <= w_head.write;
            r_add       <= w_head.write ? ADD_WRITE : ADD_READ;
            if (w_head.write) r_ext_wdata <= DATA_W'(w_head.wdata);
            r_timer     <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (apb_ready_i) begin
            r_add   <= ADD_IDLE;
            r_state <= CAPTURE;
          end else if (r_timer == TIMER_LAST) begin
            r_add       <= ADD_IDLE;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_write <= r_cur_write;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        // Read data from the APB top lags its ready by one cycle.
        CAPTURE: begin
          r_rsp_rdata <= r_cur_write ? '0 : apb_rdata_i;
          r_rsp_write <= r_cur_write;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef APB_SEQ_STATS_EN
  logic [15:0] r_wr_done;
  logic [15:0] r_rd_done;
  logic [15:0] r_err_cnt;
  logic        w_rsp_hs;

  assign w_rsp_hs = r_rsp_valid && rsp_ready_i;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_wr_done <= '0;
      r_rd_done <= '0;
      r_err_cnt <= '0;
    end else if (w_rsp_hs) begin
      if (r_rsp_err)        r_err_cnt <= sat_inc16(r_err_cnt);
      else if (r_rsp_write) r_wr_done <= sat_inc16(r_wr_done);
      else                  r_rd_done <= sat_inc16(r_rd_done);
    end
  end

  assign wr_done_o = r_wr_done;
  assign rd_done_o = r_rd_done;
  assign err_cnt_o = r_err_cnt;
`endif

  assign cmd_ready_o      = !w_full;
  assign busy_o           = (r_state != IDLE) || !w_empty;
  assign add_o            = r_add;
  assign external_wdata_o = r_ext_wdata;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_write_o      = r_rsp_write;
  assign rsp_rdata_o      = r_rsp_rdata;
  assign rsp_err_o        = r_rsp_err;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer (default build, stats macro undefined).
module tb_apb_cmd_sequencer;

  logic        pclk;
  logic        preset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_write_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [1:0]  add_o;
  logic [31:0] external_wdata_o;
  logic        apb_ready_i;
  logic [31:0] apb_rdata_i;
  logic        busy_o;
  logic [2:0]  fifo_count_o;

  int checks   = 0;
  int failures = 0;

  apb_cmd_sequencer #(
    .DATA_W         (32),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk             (pclk),
    .preset           (preset),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_write_i      (cmd_write_i),
    .cmd_wdata_i      (cmd_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_write_o      (rsp_write_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .add_o            (add_o),
    .external_wdata_o (external_wdata_o),
    .apb_ready_i      (apb_ready_i),
    .apb_rdata_i      (apb_rdata_i),
    .busy_o           (busy_o),
    .fifo_count_o     (fifo_count_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw;
    preset      = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;
    apb_ready_i = 1'b0;
    apb_rdata_i = '0;
    repeat (2) tick();
    chk("rst_add", add_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_ext", external_wdata_o, 0);
    preset = 1'b0;

    // Write then read
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h1234ABCD;
    tick();
    chk("wr_count_push", fifo_count_o, 1);
    chk("wr_add_early", add_o, 0);
    cmd_write_i = 1'b0; cmd_wdata_i = 32'hFFFF0000;
    tick();
    chk("wr_add_issue", add_o, 2'b11);
    chk("wr_ext", external_wdata_o, 32'h1234ABCD);
    chk("wr_count_pushpop", fifo_count_o, 1);
    cmd_valid_i = 1'b0;
    tick();
    apb_ready_i = 1'b1;
    tick();
    chk("wr_add_done", add_o, 0);
    apb_ready_i = 1'b0;
    tick();
    chk("wr_rsp_valid", rsp_valid_o, 1);
    chk("wr_rsp_write", rsp_write_o, 1);
    chk("wr_rsp_err", rsp_err_o, 0);
    chk("wr_rsp_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("wr_rsp_drop", rsp_valid_o, 0);
    tick();
    chk("rd_add_issue", add_o, 2'b01);
    chk("rd_ext_hold", external_wdata_o, 32'h1234ABCD);
    apb_rdata_i = 32'h1234ABCD;
    tick();
    apb_ready_i = 1'b1;
    tick();
    chk("rd_add_done", add_o, 0);
    apb_ready_i = 1'b0;
    tick();
    chk("rd_rsp_valid", rsp_valid_o, 1);
    chk("rd_rsp_write", rsp_write_o, 0);
    chk("rd_rsp_err", rsp_err_o, 0);
    chk("rd_rsp_rdata", rsp_rdata_o, 32'h1234ABCD);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("rd_idle_busy", busy_o, 0);
    chk("rd_idle_count", fifo_count_o, 0);

    // Timeout on a read
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("to_add_issue", add_o, 2'b01);
    repeat (15) tick();
    chk("to_add_still", add_o, 2'b01);
    chk("to_no_rsp_yet", rsp_valid_o, 0);
    tick();
    chk("to_add_abort", add_o, 0);
    chk("to_rsp_valid", rsp_valid_o, 1);
    chk("to_rsp_err", rsp_err_o, 1);
    chk("to_rsp_rdata", rsp_rdata_o, 0);
    chk("to_rsp_write", rsp_write_o, 0);

    // Response backpressure with a command waiting
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h0BADBEEF;
    tick();
    cmd_valid_i = 1'b0;
    chk("bp_count", fifo_count_o, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", rsp_valid_o, 1);
      chk("bp_err_hold", rsp_err_o, 1);
      chk("bp_no_issue", add_o, 0);
      tick();
    end
    chk("bp_count_hold", fifo_count_o, 1);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("bp_rsp_drop", rsp_valid_o, 0);
    tick();
    chk("bp_next_issue", add_o, 2'b11);
    chk("bp_next_ext", external_wdata_o, 32'h0BADBEEF);
    apb_ready_i = 1'b1; tick(); apb_ready_i = 1'b0;
    tick();
    chk("bp_next_rsp", rsp_valid_o, 1);
    chk("bp_next_err", rsp_err_o, 0);
    chk("bp_next_write", rsp_write_o, 1);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;

    // FIFO full with apb_ready stuck low
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_wdata_i = 32'h0;
    repeat (5) tick();
    chk("full_count", fifo_count_o, 4);
    chk("full_cmd_ready", cmd_ready_o, 0);
    chk("full_add", add_o, 2'b01);
    repeat (12) tick();
    chk("full_count_hold", fifo_count_o, 4);
    chk("full_ready_hold", cmd_ready_o, 0);
    chk("full_no_rsp", rsp_valid_o, 0);
    tick();
    chk("full_to_rsp", rsp_valid_o, 1);
    chk("full_to_err", rsp_err_o, 1);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("full_after_hs_count", fifo_count_o, 4);
    chk("full_after_hs_ready", cmd_ready_o, 0);
    tick();
    chk("full_pop_count", fifo_count_o, 3);
    chk("full_pop_ready", cmd_ready_o, 1);
    chk("full_pop_add", add_o, 2'b01);
    tick();
    cmd_valid_i = 1'b0;
    chk("full_sixth_push", fifo_count_o, 4);

    // Reset while in WAIT with commands queued
    preset = 1'b1;
    tick();
    chk("mrst_add", add_o, 0);
    chk("mrst_count", fifo_count_o, 0);
    chk("mrst_rsp_valid", rsp_valid_o, 0);
    chk("mrst_cmd_ready", cmd_ready_o, 1);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_ext", external_wdata_o, 0);
    preset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0 || add_o !== 2'b00) saw = 1'b1;
    end
    chk("mrst_quiet", saw, 0);

    // Stale ready guard
    apb_rdata_i = 32'hCAFEF00D;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("st_add_issue", add_o, 2'b01);
    apb_ready_i = 1'b1;
    tick();
    chk("st_add_done", add_o, 0);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h5555AAAA;
    tick();
    cmd_valid_i = 1'b0;
    chk("st_rsp_valid", rsp_valid_o, 1);
    chk("st_rsp_rdata", rsp_rdata_o, 32'hCAFEF00D);
    chk("st_rsp_write", rsp_write_o, 0);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("st_rsp_drop", rsp_valid_o, 0);
    tick();
    chk("st_blocked1", add_o, 0);
    chk("st_blocked_count", fifo_count_o, 1);
    tick();
    chk("st_blocked2", add_o, 0);
    apb_ready_i = 1'b0;
    tick();
    chk("st_issue", add_o, 2'b11);
    chk("st_ext", external_wdata_o, 32'h5555AAAA);
    apb_ready_i = 1'b1; tick(); apb_ready_i = 1'b0;
    tick();
    chk("st_final_rsp", rsp_valid_o, 1);
    chk("st_final_write", rsp_write_o, 1);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    chk("st_final_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
